// File: rtl/route_sched.sv
// route_sched: sequencer for the intermediate-register router.
// Bulk-loads the M1 result vector (or streams GSRAM words), then walks each
// slot through the LUT stage and writes the feedback back into the same slot.
module route_sched #(
   parameter int NUM_WORDS = 10,
   parameter int ADDR_W    = 4,
   parameter int LUT_LAT   = 1,
   parameter int SRAM_LAT  = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              src_sel,
   input  logic              abort,
   input  logic              m1_valid,
   output logic              reg_load_en,
   output logic              reg_load_sel,
   output logic [ADDR_W-1:0] addr,
   output logic              data_out_sel,
   output logic              sram_rd_en,
   output logic [ADDR_W-1:0] sram_addr,
   output logic              lut_valid,
   output logic              busy,
   output logic              done
);

   // Wait counter must hold the longest round trip (GSRAM read plus LUT).
   localparam int WCNT_W = $clog2(SRAM_LAT + LUT_LAT + 1);

   localparam logic [WCNT_W-1:0] WAIT_REG  = WCNT_W'(LUT_LAT);
   localparam logic [WCNT_W-1:0] WAIT_SRAM = WCNT_W'(SRAM_LAT + LUT_LAT);
   localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_M1,
      S_LOAD,
      S_RD,
      S_WAIT,
      S_WR,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   idx_q,   idx_d;
   logic [WCNT_W-1:0]   wcnt_q,  wcnt_d;
   logic                mode_q,  mode_d;

   // State register; reset clears the run without producing a done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         wcnt_q  <= '0;
         mode_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge value of the others.
         state_q <= state_d;
         idx_q   <= idx_d;
         wcnt_q  <= wcnt_d;
         mode_q  <= mode_d;
      end
   end

   // Next-state logic: word walk, LUT/GSRAM wait countdown, abort override.
   always_comb begin
      // NOTE: hold-current defaults first so no path leaves a signal unassigned (no latches).
      state_d = state_q;
      idx_d   = idx_q;
      wcnt_d  = wcnt_q;
      mode_d  = mode_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_d  = src_sel;
               idx_d   = '0;
               state_d = src_sel ? S_RD : S_WAIT_M1;
            end
         end
         S_WAIT_M1: begin
            if (m1_valid) state_d = S_LOAD;
         end
         S_LOAD: begin
            state_d = S_RD;
         end
         S_RD: begin
            wcnt_d  = mode_q ? WAIT_SRAM : WAIT_REG;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // WAIT lasts as many cycles as the value loaded in RD.
            wcnt_d = wcnt_q - WCNT_W'(1);
            if (wcnt_q == WCNT_W'(1)) state_d = S_WR;
         end
         S_WR: begin
            if (idx_q == LAST_IDX) begin
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + ADDR_W'(1);
               state_d = S_RD;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort wins over every transition but is meaningless when already idle.
      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         idx_d   = '0;
         wcnt_d  = '0;
      end
   end

   // Moore output decode from registered state, index and mode.
   always_comb begin
      reg_load_en  = 1'b0;
      reg_load_sel = 1'b0;
      addr         = '0;
      data_out_sel = 1'b0;
      sram_rd_en   = 1'b0;
      sram_addr    = '0;
      lut_valid    = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;

      unique case (state_q)
         S_WAIT_M1: begin
            busy         = 1'b1;
            data_out_sel = mode_q;
         end
         S_LOAD: begin
            reg_load_en  = 1'b1;
            busy         = 1'b1;
            data_out_sel = mode_q;
         end
         S_RD: begin
            addr         = idx_q;
            busy         = 1'b1;
            lut_valid    = 1'b1;
            data_out_sel = mode_q;
            sram_rd_en   = mode_q;
            sram_addr    = mode_q ? idx_q : '0;
         end
         S_WAIT: begin
            addr         = idx_q;
            busy         = 1'b1;
            lut_valid    = 1'b1;
            data_out_sel = mode_q;
            sram_addr    = mode_q ? idx_q : '0;
         end
         S_WR: begin
            reg_load_en  = 1'b1;
            reg_load_sel = 1'b1;
            addr         = idx_q;
            busy         = 1'b1;
            lut_valid    = 1'b1;
            data_out_sel = mode_q;
         end
         S_DONE: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule
